apb_cfg_seq: RTL and testbench

APB_CFG_SEQ -- requirements
Module: apb_cfg_seq

---
 rtl/apb_cfg_seq_if.sv | 24 ++
 rtl/apb_cfg_seq.sv | 155 +++++++++++++++
 tb/tb_apb_cfg_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cfg_seq_if.sv
// APB master bus bundle for the config sequencer.
// Latency: none, wires only. Backpressure: slave holds i_apb_PREADY low to extend ACCESS.
interface apb_cfg_seq_if #(
    parameter int APB_SEL_WIDTH  = 4,
    parameter int APB_ADDR_WIDTH = 10,
    parameter int APB_DATA_WIDTH = 32
);
    logic [APB_ADDR_WIDTH-1:0] o_apb_PADDR;
    logic [APB_SEL_WIDTH-1:0]  o_apb_PSEL;
    logic                      o_apb_PENABLE;
    logic                      o_apb_PWRITE;
    logic [APB_DATA_WIDTH-1:0] o_apb_PWDATA;
    logic                      i_apb_PREADY;

    modport master (
        output o_apb_PADDR, o_apb_PSEL, o_apb_PENABLE, o_apb_PWRITE, o_apb_PWDATA,
        input  i_apb_PREADY
    );

    modport slave (
        input  o_apb_PADDR, o_apb_PSEL, o_apb_PENABLE, o_apb_PWRITE, o_apb_PWDATA,
        output i_apb_PREADY
    );
endinterface

// File: rtl/apb_cfg_seq.sv
// Replays a register table as APB writes, starting on the vsync rising edge after an update request.
// Latency: first SETUP the cycle after the edge is seen; 2 cycles per entry while PREADY is high.
// Backpressure: PREADY low holds ACCESS; table writes during a run are dropped and flagged.
module apb_cfg_seq #(
    parameter int APB_SEL_WIDTH  = 4,
    parameter int APB_ADDR_WIDTH = 10,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TBL_DEPTH      = 64,
    localparam int IDX_W         = $clog2(TBL_DEPTH)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_vs,
    input  logic                      i_update_req,
    input  logic [IDX_W:0]            i_num_entries,
    input  logic                      i_tbl_we,
    input  logic [IDX_W-1:0]          i_tbl_idx,
    input  logic [APB_SEL_WIDTH-1:0]  i_tbl_sel,
    input  logic [APB_ADDR_WIDTH-1:0] i_tbl_addr,
    input  logic [APB_DATA_WIDTH-1:0] i_tbl_data,
    apb_cfg_seq_if.master             apb,
    output logic                      o_busy,
    output logic                      o_pending,
    output logic                      o_done,
    output logic                      o_tbl_err
);
    typedef enum logic [2:0] {IDLE, ARM, SETUP, ACCESS, DONE} state_t;

    typedef struct packed {
        logic [APB_SEL_WIDTH-1:0]  sel;
        logic [APB_ADDR_WIDTH-1:0] addr;
        logic [APB_DATA_WIDTH-1:0] data;
    } ent_t;

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(TBL_DEPTH);
    localparam logic [IDX_W:0] ONE_C   = (IDX_W+1)'(1);

    ent_t             tbl [TBL_DEPTH];
    ent_t             ent_nxt;
    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W:0]   cnt, cnt_nxt, num_clamped, idx_p1;
    logic             vs_d, vs_rise, pending, pending_nxt, run_act;

    logic [APB_SEL_WIDTH-1:0]  psel_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_d;
    logic                      penable_d, pwrite_d, tbl_err_d;

    assign num_clamped = (i_num_entries > DEPTH_C) ? DEPTH_C : i_num_entries;
    assign vs_rise     = i_vs & ~vs_d;
    assign idx_p1      = {1'b0, idx} + ONE_C;
    assign run_act     = (state == SETUP) || (state == ACCESS);

    // Table has no reset; it is only writable while no run is in flight.
    always_ff @(posedge clk) begin
        if (i_tbl_we && (state == IDLE || state == ARM)) begin
            tbl[i_tbl_idx] <= '{sel: i_tbl_sel, addr: i_tbl_addr, data: i_tbl_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            vs_d    <= 1'b0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            vs_d    <= i_vs;
            pending <= pending_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = cnt;
        pending_nxt = pending;
        // A request arriving mid-run is queued for the following frame.
        if (i_update_req && (run_act || state == DONE)) pending_nxt = 1'b1;
        case (state)
            IDLE: begin
                if (i_update_req) begin
                    state_nxt   = ARM;
                    pending_nxt = 1'b1;
                end
            end
            ARM: begin
                if (vs_rise) begin
                    cnt_nxt     = num_clamped;
                    idx_nxt     = '0;
                    pending_nxt = 1'b0;
                    state_nxt   = (num_clamped == '0) ? DONE : SETUP;
                end
            end
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                if (apb.i_apb_PREADY) begin
                    if (idx_p1 < cnt) begin
                        idx_nxt   = idx_p1[IDX_W-1:0];
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE:    state_nxt = pending_nxt ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // APB values are computed from the next state so the bus is registered and aligned with state.
    always_comb begin
        ent_nxt   = tbl[idx_nxt];
        psel_d    = '0;
        paddr_d   = '0;
        pwdata_d  = '0;
        pwrite_d  = 1'b0;
        penable_d = 1'b0;
        tbl_err_d = i_tbl_we && run_act;
        if (state_nxt == SETUP || state_nxt == ACCESS) begin
            psel_d    = ent_nxt.sel;
            paddr_d   = ent_nxt.addr;
            pwdata_d  = ent_nxt.data;
            pwrite_d  = 1'b1;
            penable_d = (state_nxt == ACCESS);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            apb.o_apb_PSEL    <= '0;
            apb.o_apb_PADDR   <= '0;
            apb.o_apb_PWDATA  <= '0;
            apb.o_apb_PWRITE  <= 1'b0;
            apb.o_apb_PENABLE <= 1'b0;
            o_tbl_err         <= 1'b0;
        end else begin
            apb.o_apb_PSEL    <= psel_d;
            apb.o_apb_PADDR   <= paddr_d;
            apb.o_apb_PWDATA  <= pwdata_d;
            apb.o_apb_PWRITE  <= pwrite_d;
            apb.o_apb_PENABLE <= penable_d;
            o_tbl_err         <= tbl_err_d;
        end
    end

    assign o_busy    = run_act;
    assign o_done    = (state == DONE);
    assign o_pending = pending;
endmodule

// File: tb/tb_apb_cfg_seq.sv
// Scoreboard bench for apb_cfg_seq: stimulus pushes expected transfers/events, a negedge monitor pops and compares.
module tb_apb_cfg_seq;
    localparam int SW = 4, AW = 10, DW = 32, DEPTH = 64, IW = 6;

    logic clk = 1'b0, rstn = 1'b0, i_vs = 1'b0, i_update_req = 1'b0, i_tbl_we = 1'b0, pready = 1'b1;
    logic [IW:0]   i_num_entries = '0;
    logic [IW-1:0] i_tbl_idx = '0;
    logic [SW-1:0] i_tbl_sel = '0;
    logic [AW-1:0] i_tbl_addr = '0;
    logic [DW-1:0] i_tbl_data = '0;
    logic o_busy, o_pending, o_done, o_tbl_err;

    apb_cfg_seq_if #(.APB_SEL_WIDTH(SW), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) apb ();
    assign apb.i_apb_PREADY = pready;

    apb_cfg_seq #(.APB_SEL_WIDTH(SW), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TBL_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .i_vs(i_vs), .i_update_req(i_update_req),
        .i_num_entries(i_num_entries), .i_tbl_we(i_tbl_we), .i_tbl_idx(i_tbl_idx),
        .i_tbl_sel(i_tbl_sel), .i_tbl_addr(i_tbl_addr), .i_tbl_data(i_tbl_data),
        .apb(apb), .o_busy(o_busy), .o_pending(o_pending), .o_done(o_done), .o_tbl_err(o_tbl_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic bad_event(input string name, input int at);
        n_chk++;
        $display("FAIL %s: unexpected event at cycle %0d, expected none", name, at);
    endtask

    typedef struct {
        logic [SW-1:0] sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
        int            acc;
    } xfer_t;

    xfer_t xfer_q[$];
    int    done_q[$];
    int    err_q[$];

    logic [SW-1:0] m_sel  [DEPTH];
    logic [AW-1:0] m_addr [DEPTH];
    logic [DW-1:0] m_data [DEPTH];

    // Monitor state
    xfer_t         m_e;
    int            m_x;
    logic [SW-1:0] c_sel;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data;
    int            c_cyc = 0, c_acc = 0;
    logic          c_hold = 1'b0;
    int            idle_bad = 0, busy_bad = 0;

    always @(negedge clk) begin
        if (rstn) begin
            if (apb.o_apb_PSEL == '0) begin
                if (apb.o_apb_PENABLE || apb.o_apb_PWRITE || apb.o_apb_PADDR != '0 || apb.o_apb_PWDATA != '0)
                    idle_bad++;
            end
            if (o_busy != (apb.o_apb_PSEL != '0)) busy_bad++;
            if (apb.o_apb_PSEL != '0 && !apb.o_apb_PENABLE) begin
                c_sel  = apb.o_apb_PSEL;
                c_addr = apb.o_apb_PADDR;
                c_data = apb.o_apb_PWDATA;
                c_cyc  = cyc;
                c_acc  = 0;
                c_hold = apb.o_apb_PWRITE;
            end else if (apb.o_apb_PENABLE) begin
                c_acc++;
                if (apb.o_apb_PSEL != c_sel || apb.o_apb_PADDR != c_addr ||
                    apb.o_apb_PWDATA != c_data || !apb.o_apb_PWRITE)
                    c_hold = 1'b0;
                if (pready) begin
                    if (xfer_q.size() == 0) bad_event("xfer", cyc);
                    else begin
                        m_e = xfer_q.pop_front();
                        chk("xfer_payload", {c_sel, c_addr, c_data}, {m_e.sel, m_e.addr, m_e.data});
                        chk("xfer_setup_cycle", c_cyc, m_e.cyc);
                        chk("xfer_access_len", c_acc, m_e.acc);
                        chk("xfer_hold", c_hold, 1);
                    end
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) bad_event("done", cyc);
                else begin
                    m_x = done_q.pop_front();
                    chk("done_cycle", cyc, m_x);
                end
            end
            if (o_tbl_err) begin
                if (err_q.size() == 0) bad_event("tbl_err", cyc);
                else begin
                    m_x = err_q.pop_front();
                    chk("tbl_err_cycle", cyc, m_x);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        i_tbl_we = 1'b1; i_tbl_idx = IW'(i); i_tbl_sel = s; i_tbl_addr = a; i_tbl_data = d;
        m_sel[i] = s; m_addr[i] = a; m_data[i] = d;
        tick(1);
        i_tbl_we = 1'b0;
    endtask

    task automatic arm();
        i_update_req = 1'b1;
        tick(1);
        i_update_req = 1'b0;
        chk("pending_on_arm", o_pending, 1);
    endtask

    // Expects the DUT in ARM. Offsets are cycles after the vs rise; 0 disables that event.
    task automatic run(input int num_in, input int stall_ent, input int stall_n, input int upd_off, input int we_off);
        int  n, vc, s, acc, done_c;
        bit  stall_map [512];
        i_vs = 1'b0;
        tick(1);
        n = (num_in > DEPTH) ? DEPTH : num_in;
        i_num_entries = (IW+1)'(num_in);
        i_vs = 1'b1;
        vc = cyc;
        s = vc + 1;
        for (int i = 0; i < n; i++) begin
            acc = (i == stall_ent) ? stall_n + 1 : 1;
            xfer_q.push_back('{sel: m_sel[i], addr: m_addr[i], data: m_data[i], cyc: s, acc: acc});
            if (i == stall_ent)
                for (int k = 1; k <= stall_n; k++) stall_map[s + k - vc] = 1'b1;
            s += 1 + acc;
        end
        done_c = s;
        done_q.push_back(done_c);
        if (we_off > 0) err_q.push_back(vc + we_off + 1);
        for (int c = vc + 1; c <= done_c; c++) begin
            tick(1);
            pready       = !stall_map[c - vc];
            i_update_req = (c - vc == upd_off);
            i_tbl_we     = (c - vc == we_off);
            if (c == vc + 1) i_num_entries = (IW+1)'(1);
        end
        tick(1);
        pready = 1'b1; i_update_req = 1'b0; i_tbl_we = 1'b0; i_vs = 1'b0;
        chk("pending_after_done", o_pending, upd_off > 0);
    endtask

    initial begin
        tick(2);
        chk("reset_outputs", {apb.o_apb_PSEL, apb.o_apb_PENABLE, apb.o_apb_PWRITE, apb.o_apb_PADDR,
                              apb.o_apb_PWDATA, o_busy, o_pending, o_done, o_tbl_err}, 0);
        rstn = 1'b1;
        tick(1);

        // Basic three-entry run; second request while armed is a no-op
        wr(0, 4'b0001, 10'h010, 32'h11);
        wr(1, 4'b0010, 10'h020, 32'h22);
        wr(2, 4'b0100, 10'h030, 32'h33);
        arm();
        arm();
        run(3, -1, 0, 0, 0);

        // PREADY low for 4 cycles on entry 1
        arm();
        run(3, 1, 4, 0, 0);

        // Zero-length run
        arm();
        run(0, -1, 0, 0, 0);

        // Update during a run queues an identical second run
        arm();
        run(3, -1, 0, 3, 0);
        run(3, -1, 0, 0, 0);

        // Table write during ACCESS is rejected; re-run shows old contents
        arm();
        i_tbl_idx = IW'(1); i_tbl_sel = 4'b1000; i_tbl_addr = 10'h3FF; i_tbl_data = 32'hDEAD_BEEF;
        run(3, -1, 0, 0, 2);
        arm();
        run(3, -1, 0, 0, 0);

        // Reset in the middle of a stalled ACCESS
        arm();
        i_num_entries = (IW+1)'(3);
        pready = 1'b0;
        i_vs = 1'b0;
        tick(1);
        i_vs = 1'b1;
        tick(1);
        i_update_req = 1'b1;
        tick(1);
        i_update_req = 1'b0;
        tick(1);
        chk("pre_reset_pending", o_pending, 1);
        chk("pre_reset_penable", apb.o_apb_PENABLE, 1);
        rstn = 1'b0;
        #1;
        chk("reset_mid_access", {apb.o_apb_PSEL, apb.o_apb_PENABLE, apb.o_apb_PWRITE, apb.o_apb_PADDR,
                                 apb.o_apb_PWDATA, o_busy, o_pending, o_done, o_tbl_err}, 0);
        tick(2);
        rstn = 1'b1;
        pready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_vs = 1'b0; tick(2);
            i_vs = 1'b1; tick(2);
        end
        i_vs = 1'b0;
        tick(2);
        chk("post_reset_idle", {o_busy, o_pending}, 0);
        arm();
        run(3, -1, 0, 0, 0);

        // Full table with an oversized count clamps to DEPTH
        for (int i = 0; i < DEPTH; i++)
            wr(i, SW'(1 << (i % 4)), AW'(i * 16 + 5), 32'hA500_0000 + DW'(i));
        arm();
        run(100, -1, 0, 0, 0);

        tick(3);
        chk("xfer_q_drained", xfer_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        chk("idle_bus_zero", idle_bad, 0);
        chk("busy_matches_psel", busy_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
